// File: rtl/spi_count_pkg.sv
// ---------------------------------------------------------------------------
// spi_count_pkg
// Shared definitions for the SPI count-frame slave.
// Frame layout, MSB first on the wire: {run_mode, 1'b0, count[13:0]}.
// No ports. Provides the protocol constants, the FSM state type and the
// frame-legality check used by the receiver.
// ---------------------------------------------------------------------------
package spi_count_pkg;

    localparam int FRAME_W     = 16;
    localparam int DATA_W      = 14;
    localparam int MAX_COUNT   = 9999;
    localparam int SYNC_STAGES = 2;

    // Frame field positions.
    localparam int MODE_BIT = 15;
    localparam int RSVD_BIT = 14;

    // Bit counter must hold 0..FRAME_W inclusive.
    localparam int                CNT_W      = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  FRAME_BITS = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_e;

    // A frame is legal when the reserved bit is clear and the count field is
    // within the display range. Unsigned compare on the count field only.
    function automatic logic frame_ok(input logic [FRAME_W-1:0] frame);
        return !frame[RSVD_BIT] && (frame[DATA_W-1:0] <= DATA_W'(MAX_COUNT));
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// ---------------------------------------------------------------------------
// spi_in_sync
// Brings one asynchronous SPI control line into the clk domain and flags its
// edges. Edges are taken from the last two synchronized samples, so a pin
// edge is reported STAGES+1 clocks after it occurs.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active-high
//   async_i in  asynchronous input line
//   rise_o  out 1-clk pulse on a synchronized 0->1 transition
//   fall_o  out 1-clk pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_in_sync
    import spi_count_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // The chain resets low: after a reset taken while the line is already low
    // no falling edge is reported, so a frame in flight is not re-entered.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_count_slave.sv
// ---------------------------------------------------------------------------
// spi_count_slave
// SPI mode-0 slave, MSB first, receiving 16-bit count frames for the FND
// display datapath. Legal frames update o_count/o_mode with an o_valid
// pulse; illegal or short frames pulse o_err. MISO echoes the previously
// accepted frame so the master can verify the link.
// Ports:
//   clk      in   system clock (100 MHz)
//   rst      in   synchronous reset, active-high
//   sclk     in   SPI clock, CPOL=0 (async)
//   mosi     in   SPI data in (async)
//   ss_n     in   slave select, active-low (async)
//   miso     out  SPI data out, 0 when not shifting
//   o_count  out  last accepted count (0..9999)
//   o_mode   out  last accepted run_mode bit
//   o_valid  out  1-clk pulse when o_count/o_mode update
//   o_err    out  1-clk pulse on a rejected frame
// Requires f_sclk <= f_clk/8.
// ---------------------------------------------------------------------------
module spi_count_slave
    import spi_count_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic [DATA_W-1:0] o_count,
    output logic              o_mode,
    output logic              o_valid,
    output logic              o_err
);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .async_i(sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk    (clk),
        .rst    (rst),
        .async_i(ss_n),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // mosi only needs a level, delayed by the same depth as sclk so that the
    // sample taken on a detected rise is the bit the master presented.
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [FRAME_W-1:0]   rx_q,      rx_d;
    logic [FRAME_W-1:0]   tx_q,      tx_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    count_q,   count_d;
    logic                 mode_q,    mode_d;
    logic                 valid_q,   valid_d;
    logic                 err_q,     err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_q      <= '0;
            tx_q      <= '0;
            bit_cnt_q <= '0;
            count_q   <= '0;
            mode_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        bit_cnt_d = bit_cnt_q;
        count_d   = count_q;
        mode_d    = mode_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a fresh select edge arms the slave; sclk activity
                // while deselected never reaches SHIFT.
                if (ss_fall) begin
                    tx_d      = {mode_q, 1'b0, count_q};
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                // SHIFT is entered on a synced fall, so the first cycle the
                // synced select reads high is exactly its rising edge.
                // Deselect wins over a coincident sclk edge.
                if (ss_rise) begin
                    state_d = CHECK;
                end else begin
                    if (sclk_rise && (bit_cnt_q < FRAME_BITS)) begin
                        rx_d      = {rx_q[FRAME_W-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    // Zero fill: after the 16th shift miso stays low.
                    if (sclk_fall) begin
                        tx_d = {tx_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end

            CHECK: begin
                state_d = IDLE;
                if ((bit_cnt_q == FRAME_BITS) && frame_ok(rx_q)) begin
                    count_d = rx_q[DATA_W-1:0];
                    mode_d  = rx_q[MODE_BIT];
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign miso    = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'b0;
    assign o_count = count_q;
    assign o_mode  = mode_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_spi_count_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_count_slave
// Directed-vector bench for spi_count_slave. A bus model drives SPI mode 0 at
// sclk = clk/10 and collects miso; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_spi_count_slave;

    localparam int HALF = 5;   // clk cycles per sclk half period

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        ss_n;
    logic        miso;
    logic [13:0] o_count;
    logic        o_mode;
    logic        o_valid;
    logic        o_err;

    int n_vec  = 0;
    int n_miss = 0;

    int tot_valid = 0;
    int tot_err   = 0;
    int tot_both  = 0;

    spi_count_slave dut (
        .clk    (clk),
        .rst    (rst),
        .sclk   (sclk),
        .mosi   (mosi),
        .ss_n   (ss_n),
        .miso   (miso),
        .o_count(o_count),
        .o_mode (o_mode),
        .o_valid(o_valid),
        .o_err  (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping: counts clk cycles each pulse output is high.
    always @(negedge clk) begin
        if (o_valid)          tot_valid <= tot_valid + 1;
        if (o_err)            tot_err   <= tot_err + 1;
        if (o_valid && o_err) tot_both  <= tot_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Select, then clock nbits out MSB first; bits past 16 send mosi=1.
    // rx collects miso sampled just before each rising sclk.
    task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? tx[15 - i] : 1'b1;
            repeat (HALF) @(negedge clk);
            rx   = {rx[30:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Deselect and measure clocks until a pulse; 99 means none in the window.
    task automatic spi_end(output int lat);
        lat  = 99;
        ss_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((o_valid || o_err) && lat == 99) lat = k;
        end
    endtask

    task automatic do_frame(input string tag, input logic [15:0] tx, input int nbits,
                            input logic [31:0] exp_rx, input bit exp_ok,
                            input logic [13:0] exp_count, input logic exp_mode);
        int          v0;
        int          e0;
        int          lat;
        logic [31:0] rx;
        v0 = tot_valid;
        e0 = tot_err;
        spi_xfer(tx, nbits, rx);
        spi_end(lat);
        check({tag, ":latency"}, lat, 4);
        check({tag, ":valid"},   tot_valid - v0, exp_ok ? 1 : 0);
        check({tag, ":err"},     tot_err - e0,   exp_ok ? 0 : 1);
        check({tag, ":count"},   o_count, exp_count);
        check({tag, ":mode"},    o_mode,  exp_mode);
        check({tag, ":miso"},    rx,      exp_rx);
    endtask

    initial begin
        int          v0;
        int          e0;
        int          lat;
        logic [31:0] rx;

        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("rst:count", o_count, 0);
        check("rst:mode",  o_mode,  0);
        check("rst:valid", o_valid, 0);
        check("rst:err",   o_err,   0);
        check("rst:miso",  miso,    0);

        //        tag       frame     bits expected miso   ok  count  mode
        do_frame("f3333",  16'h0D05, 16, 32'h0000_0000, 1, 14'd3333, 1'b0);
        do_frame("f9999",  16'hA70F, 16, 32'h0000_0D05, 1, 14'd9999, 1'b1);
        do_frame("f10000", 16'h2710, 16, 32'h0000_A70F, 0, 14'd9999, 1'b1);
        do_frame("fbit14", 16'h4001, 16, 32'h0000_A70F, 0, 14'd9999, 1'b1);
        do_frame("f1",     16'h0001, 16, 32'h0000_A70F, 1, 14'd1,    1'b0);
        // 9 bits of echo 0x0001 MSB first are all zero.
        do_frame("short9", 16'h0007, 9,  32'h0000_0000, 0, 14'd1,    1'b0);
        do_frame("f7",     16'h0007, 16, 32'h0000_0001, 1, 14'd7,    1'b0);
        // Echo 0x0007 in the first 16 samples, then four zero samples.
        do_frame("long20", 16'h0010, 20, 32'h0000_0070, 1, 14'd16,   1'b0);

        // sclk toggling while deselected: no pulses, no change.
        v0 = tot_valid;
        e0 = tot_err;
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("idle_sclk:pulses", (tot_valid - v0) + (tot_err - e0), 0);
        check("idle_sclk:count",  o_count, 16);
        check("idle_sclk:miso",   miso,    0);

        // Select glitch between clk edges: never sampled, no pulse.
        v0 = tot_valid;
        e0 = tot_err;
        @(negedge clk);
        #1 ss_n = 1'b0;
        #2 ss_n = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch:pulses", (tot_valid - v0) + (tot_err - e0), 0);

        // Reset after 8 bits of a frame: outputs cleared, frame lost.
        v0 = tot_valid;
        e0 = tot_err;
        spi_xfer(16'h0064, 8, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst:count", o_count, 0);
        check("midrst:mode",  o_mode,  0);
        check("midrst:miso",  miso,    0);
        spi_end(lat);
        check("midrst:latency", lat, 99);
        check("midrst:pulses", (tot_valid - v0) + (tot_err - e0), 0);

        do_frame("f100",   16'h0064, 16, 32'h0000_0000, 1, 14'd100,  1'b0);

        check("overlap", tot_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
